// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing control for a 5-stage pipeline: purely combinational outputs, zero latency; LSU waits freeze F..M.
// HAZARD_PERF_CNT_EN adds stall/flush performance counters; without it the counter outputs are tied to zero.
module pipe_hazard_ctrl #(
  parameter logic [1:0] WB_SEL_LD   = 2'b01,
  parameter int         MEM_TIMEOUT = 255,
  parameter int         CNT_W       = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [4:0]       rs1_addr_D,
  input  logic [4:0]       rs2_addr_D,
  input  logic [4:0]       rs1_addr_E,
  input  logic [4:0]       rs2_addr_E,
  input  logic [4:0]       rd_addr_E,
  input  logic             rd_wren_E,
  input  logic [1:0]       wb_sel_E,
  input  logic [4:0]       rd_addr_M,
  input  logic             rd_wren_M,
  input  logic [4:0]       rd_addr_W,
  input  logic             rd_wren_W,
  input  logic             mispred_E,
  input  logic             mem_access_M,
  input  logic             mem_ready_M,
  output logic             stall_F,
  output logic             stall_D,
  output logic             stall_E,
  output logic             stall_M,
  output logic             flush_D,
  output logic             flush_E,
  output logic             flush_W,
  output logic [1:0]       fwd_a_E,
  output logic [1:0]       fwd_b_E,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [0:0]  ST_RUN      = 1'b0;
  localparam logic [0:0]  ST_MEM_WAIT = 1'b1;
  localparam logic [15:0] LP_TIMEOUT  = MEM_TIMEOUT[15:0];

  logic [0:0]  r_fsm;
  logic [15:0] r_wait_cnt;

  logic w_run;
  logic w_timeout;
  logic w_memwait;
  logic w_abort;
  logic w_loaduse;
  logic w_mis_flush;
  logic w_lu_stall;

  function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                         input logic       wren_m, input logic [4:0] rd_m,
                                         input logic       wren_w, input logic [4:0] rd_w);
    logic [1:0] sel;
    sel = 2'b00;
    if (wren_m && (rd_m != 5'd0) && (rd_m == rs))
      sel = 2'b10;
    else if (wren_w && (rd_w != 5'd0) && (rd_w == rs))
      sel = 2'b01;
    return sel;
  endfunction

  assign w_run     = ~i_rst;
  assign w_timeout = (r_fsm == ST_MEM_WAIT) && (r_wait_cnt == LP_TIMEOUT);
  assign w_memwait = w_run & mem_access_M & ~mem_ready_M & ~w_timeout;
  // The abort cycle releases the freeze but still squashes the dead access in W.
  assign w_abort   = w_run & w_timeout & mem_access_M & ~mem_ready_M;

  assign w_loaduse = w_run & rd_wren_E & (wb_sel_E == WB_SEL_LD) & (rd_addr_E != 5'd0) &
                     ((rd_addr_E == rs1_addr_D) | (rd_addr_E == rs2_addr_D));

  assign w_mis_flush = w_run & ~w_memwait & mispred_E;
  assign w_lu_stall  = ~w_memwait & ~mispred_E & w_loaduse;

  assign stall_F = w_memwait | w_lu_stall;
  assign stall_D = w_memwait | w_lu_stall;
  assign stall_E = w_memwait;
  assign stall_M = w_memwait;
  assign flush_D = w_mis_flush;
  assign flush_E = w_mis_flush | w_lu_stall;
  assign flush_W = w_memwait | w_abort;
  assign mem_err = w_abort;

  assign fwd_a_E = w_run ? fwd_sel(rs1_addr_E, rd_wren_M, rd_addr_M, rd_wren_W, rd_addr_W) : 2'b00;
  assign fwd_b_E = w_run ? fwd_sel(rs2_addr_E, rd_wren_M, rd_addr_M, rd_wren_W, rd_addr_W) : 2'b00;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_fsm      <= ST_RUN;
      r_wait_cnt <= 16'd0;
    end else begin
      case (r_fsm)
        ST_RUN: begin
          if (w_memwait) begin
            r_fsm      <= ST_MEM_WAIT;
            r_wait_cnt <= 16'd1;
          end else begin
            r_fsm      <= ST_RUN;
            r_wait_cnt <= 16'd0;
          end
        end
        default: begin
          // Ready, timeout or a dropped access all end the wait.
          if (!mem_access_M || mem_ready_M || w_timeout) begin
            r_fsm      <= ST_RUN;
            r_wait_cnt <= 16'd0;
          end else begin
            r_fsm      <= ST_MEM_WAIT;
            r_wait_cnt <= r_wait_cnt + 16'd1;
          end
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;
  logic             w_any_stall;

  assign w_any_stall = stall_F | stall_D | stall_E | stall_M;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_any_stall)
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (w_mis_flush)
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  assign stall_cnt = w_run ? r_stall_cnt : '0;
  assign flush_cnt = w_run ? r_flush_cnt : '0;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl built with MEM_TIMEOUT=4.
module tb_pipe_hazard_ctrl;

  localparam int CW = 32;

  logic          i_clk;
  logic          i_rst;
  logic [4:0]    rs1_addr_D, rs2_addr_D, rs1_addr_E, rs2_addr_E;
  logic [4:0]    rd_addr_E, rd_addr_M, rd_addr_W;
  logic          rd_wren_E, rd_wren_M, rd_wren_W;
  logic [1:0]    wb_sel_E;
  logic          mispred_E, mem_access_M, mem_ready_M;
  logic          stall_F, stall_D, stall_E, stall_M;
  logic          flush_D, flush_E, flush_W, mem_err;
  logic [1:0]    fwd_a_E, fwd_b_E;
  logic [CW-1:0] stall_cnt, flush_cnt;

  logic [31:0]   ctl;
  logic [31:0]   fwd;
  int            tests;
  int            fails;
  logic [31:0]   exp_stall;
  logic [31:0]   exp_flush;

  pipe_hazard_ctrl #(.WB_SEL_LD(2'b01), .MEM_TIMEOUT(4), .CNT_W(CW)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .rs1_addr_D(rs1_addr_D), .rs2_addr_D(rs2_addr_D),
    .rs1_addr_E(rs1_addr_E), .rs2_addr_E(rs2_addr_E),
    .rd_addr_E(rd_addr_E), .rd_wren_E(rd_wren_E), .wb_sel_E(wb_sel_E),
    .rd_addr_M(rd_addr_M), .rd_wren_M(rd_wren_M),
    .rd_addr_W(rd_addr_W), .rd_wren_W(rd_wren_W),
    .mispred_E(mispred_E), .mem_access_M(mem_access_M), .mem_ready_M(mem_ready_M),
    .stall_F(stall_F), .stall_D(stall_D), .stall_E(stall_E), .stall_M(stall_M),
    .flush_D(flush_D), .flush_E(flush_E), .flush_W(flush_W),
    .fwd_a_E(fwd_a_E), .fwd_b_E(fwd_b_E), .mem_err(mem_err),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  // {stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, flush_W, mem_err}
  assign ctl = {24'd0, stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, flush_W, mem_err};
  assign fwd = {28'd0, fwd_a_E, fwd_b_E};

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask

  // Check the control vector for the current cycle, then advance one clock.
  task automatic cyc(input string tag, input logic [7:0] e);
    #1;
    chk(tag, ctl, {24'd0, e});
    if (|e[7:4]) exp_stall++;
    if (e[3])    exp_flush++;
    tick();
  endtask

  task automatic chk_cnt(input string tag);
`ifdef HAZARD_PERF_CNT_EN
    chk({tag, "_stall_cnt"}, stall_cnt, exp_stall);
    chk({tag, "_flush_cnt"}, flush_cnt, exp_flush);
`else
    chk({tag, "_stall_cnt"}, stall_cnt, 32'd0);
    chk({tag, "_flush_cnt"}, flush_cnt, 32'd0);
`endif
  endtask

  task automatic clear_inputs;
    rs1_addr_D = 5'd0; rs2_addr_D = 5'd0; rs1_addr_E = 5'd0; rs2_addr_E = 5'd0;
    rd_addr_E = 5'd0; rd_wren_E = 1'b0; wb_sel_E = 2'b00;
    rd_addr_M = 5'd0; rd_wren_M = 1'b0; rd_addr_W = 5'd0; rd_wren_W = 1'b0;
    mispred_E = 1'b0; mem_access_M = 1'b0; mem_ready_M = 1'b0;
  endtask

  initial begin
    tests = 0; fails = 0; exp_stall = 0; exp_flush = 0;
    clear_inputs();

    // Reset: outputs forced low despite active hazard inputs.
    i_rst = 1'b1;
    mispred_E = 1'b1; mem_access_M = 1'b1;
    rd_wren_M = 1'b1; rd_addr_M = 5'd5; rs1_addr_E = 5'd5;
    #2;
    chk("rst_ctl", ctl, 32'h00);
    chk("rst_fwd", fwd, 32'h0);
    tick(); tick();
    i_rst = 1'b0;
    clear_inputs();
    #1;
    chk("post_rst_ctl", ctl, 32'h00);
    chk_cnt("post_rst");
    tick();

    // Forwarding: M over W, x0 never forwarded.
    rd_wren_M = 1'b1; rd_addr_M = 5'd5; rd_wren_W = 1'b1; rd_addr_W = 5'd5;
    rs1_addr_E = 5'd5; rs2_addr_E = 5'd0;
    #1; chk("fwd_m_prio", fwd, 32'b1000);
    rd_addr_M = 5'd0;
    #1; chk("fwd_w", fwd, 32'b0100);
    rd_addr_M = 5'd5; rs2_addr_E = 5'd5;
    #1; chk("fwd_both_m", fwd, 32'b1010);
    rd_wren_M = 1'b0; rd_addr_W = 5'd3; rs2_addr_E = 5'd3;
    #1; chk("fwd_b_w_only", fwd, 32'b0001);
    chk("fwd_no_ctl", ctl, 32'h00);
    tick();
    clear_inputs();

    // Load-use: one stall cycle, then the bubble in E clears it.
    rd_wren_E = 1'b1; wb_sel_E = 2'b01; rd_addr_E = 5'd7; rs2_addr_D = 5'd7;
    cyc("lu_rs2", 8'hC4);
    rd_wren_E = 1'b0; wb_sel_E = 2'b00; rd_addr_E = 5'd0;
    cyc("lu_bubble", 8'h00);
    rd_wren_E = 1'b1; wb_sel_E = 2'b01; rd_addr_E = 5'd0;
    cyc("lu_x0", 8'h00);
    rd_addr_E = 5'd7; wb_sel_E = 2'b00;
    cyc("lu_alu_dest", 8'h00);
    wb_sel_E = 2'b01; rs2_addr_D = 5'd0; rs1_addr_D = 5'd7;
    cyc("lu_rs1", 8'hC4);
    rs1_addr_D = 5'd0;

    // Mispredict overrides a concurrent load-use.
    rs2_addr_D = 5'd7; mispred_E = 1'b1;
    cyc("mis_over_lu", 8'h0C);
    clear_inputs();
    chk_cnt("after_mis");

    // LSU wait 3 cycles with a held mispredict; forwarding still active.
    mem_access_M = 1'b1; mispred_E = 1'b1;
    rd_wren_M = 1'b1; rd_addr_M = 5'd9; rs1_addr_E = 5'd9;
    cyc("mw_c1", 8'hF2);
    #1; chk("mw_fwd", fwd, 32'b1000);
    cyc("mw_c2", 8'hF2);
    cyc("mw_c3", 8'hF2);
    mem_ready_M = 1'b1;
    cyc("mw_release", 8'h0C);
    clear_inputs();
    cyc("mw_idle", 8'h00);

    // Timeout after 4 frozen cycles; a held access starts a fresh wait.
    mem_access_M = 1'b1;
    cyc("to_c1", 8'hF2);
    cyc("to_c2", 8'hF2);
    cyc("to_c3", 8'hF2);
    cyc("to_c4", 8'hF2);
    cyc("to_abort", 8'h03);
    cyc("to_rewait", 8'hF2);
    mem_ready_M = 1'b1;
    cyc("to_ready", 8'h00);
    clear_inputs();
    chk_cnt("after_to");

    // Reset during the second wait cycle: no mem_err, state and counters cleared.
    mem_access_M = 1'b1;
    cyc("rw_c1", 8'hF2);
    i_rst = 1'b1;
    cyc("rw_rst", 8'h00);
    i_rst = 1'b0;
    exp_stall = 0; exp_flush = 0;
    chk_cnt("rw_post_rst");
    cyc("rw2_c1", 8'hF2);
    cyc("rw2_c2", 8'hF2);
    cyc("rw2_c3", 8'hF2);
    cyc("rw2_c4", 8'hF2);
    cyc("rw2_abort", 8'h03);
    clear_inputs();
    cyc("end_idle", 8'h00);
    chk_cnt("final");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central hazard and sequencing controller for the 5-stage RISC-V pipeline (F/D, D/E, E/M, M/W registers).
- Drives per-register stall/flush, EX-stage forwarding selects, and a memory-wait FSM with timeout for the LSU in M.
- Handles load-use stalls, branch-mispredict flushes from E, and multi-cycle LSU accesses that freeze the E/M register.

Parameters:
- WB_SEL_LD, 2'b01, wb_sel encoding meaning "write back load data".
- MEM_TIMEOUT, 255, max stall cycles per LSU access before abort (range 2..65535).
- CNT_W, 32, width of performance counters.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  reset, synchronous, active-high.
- rs1_addr_D / rs2_addr_D  in  5 each  source registers of instruction in D.
- rs1_addr_E / rs2_addr_E  in  5 each  source registers of instruction in E.
- rd_addr_E, rd_wren_E, wb_sel_E  in  5/1/2  destination info, instruction in E.
- rd_addr_M, rd_wren_M  in  5/1  destination info, instruction in M.
- rd_addr_W, rd_wren_W  in  5/1  destination info, instruction in W.
- mispred_E  in  1  branch/jump misprediction resolved in E.
- mem_access_M  in  1  load/store in M.
- mem_ready_M  in  1  LSU completion, same cycle.
- stall_F, stall_D, stall_E, stall_M  out  1 each  hold PC, F/D, D/E, E/M registers.
- flush_D, flush_E, flush_W  out  1 each  clear F/D, D/E, M/W registers at next edge.
- fwd_a_E, fwd_b_E  out  2 each  operand select: 00 regfile, 01 W result, 10 M result.
- mem_err  out  1  one-cycle pulse on LSU timeout.
- stall_cnt, flush_cnt  out  CNT_W each  performance counters (optional feature).

Behaviour:
- All outputs are combinational from inputs and state. Registered state is fsm (RUN, MEM_WAIT), wait_cnt (16b) and the counters.
- While i_rst=1: all outputs 0. Next edge: fsm=RUN, wait_cnt=0, counters=0.
- Forwarding, per operand X in {a,b}, using rsX_addr_E:
  - 10 if rd_wren_M, rd_addr_M!=0 and rd_addr_M==rsX.
  - else 01 if rd_wren_W, rd_addr_W!=0 and rd_addr_W==rsX.
  - else 00.
  - M has priority over W. x0 is never forwarded. Forwarding is independent of stalls.
- memwait = mem_access_M & ~mem_ready_M & ~timeout, where timeout = (fsm==MEM_WAIT) & (wait_cnt==MEM_TIMEOUT).
- loaduse = rd_wren_E & wb_sel_E==WB_SEL_LD & rd_addr_E!=0 & (rd_addr_E==rs1_addr_D | rd_addr_E==rs2_addr_D).
- Priority, highest first:
  1. memwait: stall_F=stall_D=stall_E=stall_M=1, flush_W=1, all other flushes 0. mispred_E and loaduse are suppressed; they re-evaluate once released (E is held, so mispred_E persists).
  2. mispred_E: flush_D=flush_E=1, no stalls. A load-use hazard in the same cycle is discarded because the D instruction is squashed.
  3. loaduse: stall_F=stall_D=1, flush_E=1 (bubble into E). Exactly one stall cycle per hazard.
  4. otherwise all 0.
- FSM, RUN:
  - If memwait: go to MEM_WAIT, wait_cnt<=1.
  - Else stay in RUN, wait_cnt<=0.
- FSM, MEM_WAIT:
  - If mem_ready_M: stalls release this cycle, go to RUN, wait_cnt<=0.
  - Else if timeout: mem_err=1, stalls release, flush_W=1 (the aborted access produces no writeback), go to RUN, wait_cnt<=0.
  - Else wait_cnt<=wait_cnt+1.
  - If mem_access_M drops without ready (illegal case), return to RUN.
- Total freeze is at most MEM_TIMEOUT cycles per access. mem_err is never asserted outside MEM_WAIT.
- Reset asserted mid-MEM_WAIT aborts the wait with no mem_err.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- Defined:
  - stall_cnt increments each cycle any stall_* is 1.
  - flush_cnt increments each cycle mispred_E causes a flush.
  - Both wrap modulo 2^CNT_W and are cleared by i_rst.
- Undefined: both outputs tied to 0 and no counter flops are generated.

Test Plan:
- rd_wren_M=1, rd_addr_M=5, rd_wren_W=1, rd_addr_W=5, rs1_addr_E=5, rs2_addr_E=0 -> fwd_a_E=10, fwd_b_E=00. Repeat with rd_addr_M=0 and rd_addr_W=5 -> fwd_a_E=01.
- Load in E (wb_sel_E=01, rd_addr_E=7, rd_wren_E=1), rs2_addr_D=7 -> stall_F=stall_D=flush_E=1 for exactly 1 cycle. Same stimulus with rd_addr_E=0 -> no stall.
- mispred_E=1 together with the load-use condition -> flush_D=flush_E=1, stall_F=stall_D=0; flush_cnt increments by 1 when the feature is enabled.
- mem_access_M=1, mem_ready_M=0 for 3 cycles then 1 -> stall_F/D/E/M=1 and flush_W=1 for 3 cycles, released on the ready cycle, mem_err=0. A concurrent mispred_E held through the wait flushes only on the release cycle.
- MEM_TIMEOUT=4, mem_ready_M held 0 -> stalls for cycles 1-4, then mem_err=1 on the timeout cycle with stalls 0 and flush_W=1, FSM back in RUN. If mem_access_M stays high, a new wait starts on the next cycle.
- i_rst=1 asserted in MEM_WAIT cycle 2 -> outputs 0 that cycle; after reset FSM=RUN, wait_cnt=0, counters=0, no mem_err.
